dac_pattern_player: RTL and testbench
=====================================

Name: dac_pattern_player

Overview:
- Return path to the ADC capture chain: plays host-supplied DAC codes out at a programmable sample rate, for example to stimulate the ADC under test.
- Host writes 16-bit words through a pipe-in strobe interface into an internal circular buffer.
- Playback FSM pops (stream mode) or replays (loop mode) the buffer to a registered DAC code output.
- Sits between the FrontPanel pipe-in endpoint and the DAC pins. All host-side signals are already synchronous to clk.

Parameters:
- PRECISION, 10: DAC code width in bits (at most 16).
- DEPTH_LOG2, 10: buffer depth = 2^DEPTH_LOG2 words.
- DIV_WIDTH, 16: width of the sample-rate divider.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- pipe_wr_en  in  1  host write strobe; one word per cycle.
- pipe_din  in  16  host word; bits [PRECISION-1:0] are used, upper bits ignored.
- start  in  1  single-cycle pulse; begins playback.
- stop  in  1  single-cycle pulse; ends playback.
- loop_en  in  1  sampled on start: 1 = loop mode, 0 = stream mode.
- rate_div  in  DIV_WIDTH  one sample is emitted every rate_div+1 cycles.
- dac_code  out  PRECISION  registered code to the DAC.
- dac_valid  out  1  one-cycle pulse on each dac_code update.
- busy  out  1  high in PLAY or UNDERRUN.
- full  out  1  level == 2^DEPTH_LOG2.
- level  out  DEPTH_LOG2+1  words held in the buffer.
- underflow  out  1  sticky; cleared only by rst.
- overflow  out  1  sticky; cleared only by rst.

Behaviour:
- Reset values:
  - All outputs are 0.
  - Pointers are 0, divider counter is 0, state is IDLE, stored loop mode is 0.
  - rst asserted mid-playback aborts on the same edge; buffer contents are discarded (level = 0).
- Write side:
  - pipe_wr_en with !full and not (PLAY/UNDERRUN in loop mode): store word at wr_ptr, wr_ptr+1 modulo depth, level+1.
  - Write while full: word dropped, overflow set.
  - Write during loop playback: word dropped, overflow set.
- Divider:
  - Counter runs only in PLAY/UNDERRUN.
  - tick = (cnt == rate_div); cnt returns to 0 on tick, otherwise increments.
  - rate_div = 0 gives a tick every cycle.
  - cnt is cleared on entry to PLAY, so the first tick occurs rate_div+1 cycles after start.
  - rate_div changes take effect at the next compare.
- FSM states: IDLE, PLAY, UNDERRUN.
  - IDLE -> PLAY on start if level > 0; the loop_en value is stored.
  - IDLE on start with level == 0: set underflow, stay IDLE.
  - PLAY/UNDERRUN -> IDLE on stop. stop wins over a simultaneous start or tick.
  - start while busy is ignored.
- PLAY, stream mode, on tick with level > 0:
  - dac_code <= mem[rd_ptr]; dac_valid = 1 on that same edge.
  - rd_ptr+1 modulo depth; level-1.
  - A simultaneous write and pop leave level unchanged.
- PLAY, stream mode, on tick with level == 0:
  - Set underflow, dac_code holds, no dac_valid; go to UNDERRUN.
- UNDERRUN: on tick with level > 0, emit as in PLAY and return to PLAY. Data is never emitted between ticks.
- PLAY, loop mode, on tick:
  - Emit mem[rd_ptr] without popping; level is constant.
  - Next read is rd_ptr+1, or wraps to the loop base when rd_ptr+1 == wr_ptr (modulo depth).
  - The loop base is the rd_ptr value at start.
- On exit from loop mode (stop), rd_ptr restores to the loop base, so the buffer is intact for replay.
- dac_code holds its last value in IDLE.
- Memory:
  - Inferable as block RAM with a registered output.
  - The implementation prefetches the head word so the tick-to-dac_code latency is exactly one edge (dac_code changes on the tick edge).
  - Prefetch is refreshed after any write into an empty buffer.

Optional Feature:
- Macro: DAC_TWOS_COMP_EN.
- Defined: input data is two's complement and dac_code is converted to offset binary by inverting bit PRECISION-1 before registering (stored word 0 -> dac_code 0x200 at PRECISION = 10).
- Undefined: dac_code is the stored word unchanged.

Test Plan:
- Reset, write 4 words 0x001..0x004, rate_div = 2, start (stream) -> dac_valid every 3 cycles, codes 1, 2, 3, 4; then UNDERRUN, underflow = 1, dac_code holds 0x004, level = 0.
- Write 3 words 0x0A, 0x0B, 0x0C, rate_div = 0, start with loop_en = 1 -> codes A, B, C, A, B, C... on consecutive cycles; level stays 3; stop -> IDLE; a second start replays from 0x0A.
- Write 2^DEPTH_LOG2 + 1 words -> full = 1, level = 1024, overflow = 1; the last word is never emitted.
- Stream with rate_div = 0 while the host writes 1 word per cycle -> level constant, no underflow, codes in write order.
- Start on an empty buffer -> busy stays 0, underflow = 1. Assert start and stop on the same cycle with data present -> stays IDLE.
- rst mid-playback at rate_div = 5 -> next cycle all outputs are 0 and level = 0. With DAC_TWOS_COMP_EN defined, word 0x3FF -> dac_code 0x1FF.

Source files
------------

// File: rtl/dac_pattern_player.sv
// dac_pattern_player: host pipe-in circular buffer played to a DAC at a programmable rate.
// Define DAC_TWOS_COMP_EN to treat stored words as two's complement and output offset binary.
module dac_pattern_player #(
    parameter int PRECISION  = 10,
    parameter int DEPTH_LOG2 = 10,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_wr_en,
    input  logic [15:0]          pipe_din,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop_en,
    input  logic [DIV_WIDTH-1:0] rate_div,
    output logic [PRECISION-1:0] dac_code,
    output logic                 dac_valid,
    output logic                 busy,
    output logic                 full,
    output logic [DEPTH_LOG2:0]  level,
    output logic                 underflow,
    output logic                 overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW = DEPTH_LOG2 + 1;
    typedef enum logic [1:0] {IDLE, PLAY, UNDERRUN} state_t;
    state_t state, state_nx;
    logic [PRECISION-1:0] mem [DEPTH];
    logic [PRECISION-1:0] head, code_nx;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_inc, rd_nx, base;
    logic [DIV_WIDTH-1:0] cnt;
    logic loop_mode, empty, tick, wr_ok, go, emit, pop, uf_set;
    logic unused_din;
    assign unused_din = ^pipe_din;
    assign busy = state != IDLE;
    assign empty = level == '0;
    assign full = level == LW'(DEPTH);
    assign tick = busy && cnt == rate_div;
    assign wr_ok = pipe_wr_en && !full && !(busy && loop_mode);
    assign pop = emit && !loop_mode;
    assign rd_inc = rd_ptr + DEPTH_LOG2'(1);
    assign rd_nx = (busy && stop && loop_mode) ? base :
                   !emit ? rd_ptr :
                   (loop_mode && rd_inc == wr_ptr) ? base : rd_inc;
`ifdef DAC_TWOS_COMP_EN
    assign code_nx = {~head[PRECISION-1], head[PRECISION-2:0]};
`else
    assign code_nx = head;
`endif
    always_comb begin
        state_nx = state;
        go = 1'b0;
        emit = 1'b0;
        uf_set = 1'b0;
        if (state == IDLE) begin
            go = start && !stop && !empty;
            uf_set = start && !stop && empty;
            state_nx = go ? PLAY : IDLE;
        end else if (stop) begin
            state_nx = IDLE;
        end else if (tick) begin
            emit = loop_mode || !empty;
            uf_set = !emit;
            state_nx = emit ? PLAY : UNDERRUN;
        end
    end
    // head always mirrors mem[rd_ptr]; the bypass covers a write landing on the next read slot
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= pipe_din[PRECISION-1:0];
        head <= (wr_ok && wr_ptr == rd_nx) ? pipe_din[PRECISION-1:0] : mem[rd_nx];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            base <= '0;
            level <= '0;
            cnt <= '0;
            loop_mode <= 1'b0;
            dac_code <= '0;
            dac_valid <= 1'b0;
            underflow <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (wr_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            rd_ptr <= rd_nx;
            if (go) begin
                base <= rd_ptr;
                loop_mode <= loop_en;
            end
            level <= level + LW'(wr_ok) - LW'(pop);
            cnt <= (!busy || tick || stop) ? '0 : cnt + DIV_WIDTH'(1);
            dac_valid <= emit;
            if (emit) dac_code <= code_nx;
            underflow <= underflow | uf_set;
            overflow <= overflow | (pipe_wr_en && !wr_ok);
        end
    end
endmodule

// File: tb/tb_dac_pattern_player.sv
// tb_dac_pattern_player: vector table, directed corner sequences and a randomized run against a queue-based model.
module tb_dac_pattern_player;
    localparam int P = 10;
    localparam int D = 10;
    localparam int W = 16;
    localparam int DEPTH = 1 << D;
`ifdef DAC_TWOS_COMP_EN
    localparam int TC_EXP = 'h1FF;
`else
    localparam int TC_EXP = 'h3FF;
`endif
    logic clk = 1'b0;
    logic rst, wr, start, stop, loop_en;
    logic [15:0] din;
    logic [W-1:0] rate_div;
    logic [P-1:0] dac_code;
    logic dac_valid, busy, full, underflow, overflow;
    logic [D:0] level;
    dac_pattern_player #(.PRECISION(P), .DEPTH_LOG2(D), .DIV_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .pipe_wr_en(wr), .pipe_din(din), .start(start), .stop(stop),
        .loop_en(loop_en), .rate_div(rate_div), .dac_code(dac_code), .dac_valid(dac_valid),
        .busy(busy), .full(full), .level(level), .underflow(underflow), .overflow(overflow)
    );
    always #5 clk = ~clk;
    typedef struct {int wr; int din; int start; int code; int valid; int busy; int lvl; int uf;} vec_t;
    vec_t tbl[20];
    int c[5];
    int n_cmp = 0;
    int n_bad = 0;
    logic [P-1:0] mq[$];
    logic [P-1:0] seen[$];
    logic [P-1:0] m_code;
    int m_st, m_idx, m_cnt;
    bit m_loop, m_valid, m_uf, m_of;

    function automatic logic [P-1:0] cv(input logic [P-1:0] w);
        logic [P-1:0] m;
        m = '0;
`ifdef DAC_TWOS_COMP_EN
        m[P-1] = 1'b1;
`endif
        return w ^ m;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // buffer as a queue: stream pops the front, loop walks an index that restarts at the front
    task automatic model_step();
        bit m_busy, tick, wr_ok;
        if (rst) begin
            mq.delete();
            m_st = 0; m_idx = 0; m_cnt = 0;
            m_loop = 0; m_valid = 0; m_uf = 0; m_of = 0;
            m_code = '0;
            return;
        end
        m_busy = m_st != 0;
        tick = m_busy && m_cnt == int'(rate_div);
        wr_ok = wr && mq.size() < DEPTH && !(m_busy && m_loop);
        if (wr && !wr_ok) m_of = 1;
        m_valid = 0;
        if (!m_busy) begin
            m_cnt = 0;
            if (start && !stop) begin
                if (mq.size() > 0) begin
                    m_st = 1; m_loop = loop_en; m_idx = 0;
                end else m_uf = 1;
            end
        end else if (stop) begin
            m_st = 0; m_idx = 0; m_cnt = 0;
        end else if (!tick) begin
            m_cnt++;
        end else begin
            m_cnt = 0;
            if (m_loop) begin
                m_code = cv(mq[m_idx]); m_valid = 1; m_idx = (m_idx + 1) % mq.size();
            end else if (mq.size() > 0) begin
                m_code = cv(mq.pop_front()); m_valid = 1; m_st = 1;
            end else begin
                m_uf = 1; m_st = 2;
            end
        end
        if (wr_ok) mq.push_back(din[P-1:0]);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        if (dac_valid) seen.push_back(dac_code);
        chk("code", int'(dac_code), int'(m_code));
        chk("valid", int'(dac_valid), int'(m_valid));
        chk("busy", int'(busy), int'(m_st != 0));
        chk("full", int'(full), int'(mq.size() == DEPTH));
        chk("level", int'(level), mq.size());
        chk("underflow", int'(underflow), int'(m_uf));
        chk("overflow", int'(overflow), int'(m_of));
    endtask

    task automatic clr();
        wr = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; din = '0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int ord;
        int lp[7] = '{'h0A, 'h0B, 'h0C, 'h0A, 'h0B, 'h0C, 'h0A};
        for (int k = 0; k < 5; k++) c[k] = int'(cv(P'(k)));
        tbl[0]  = '{1, 1, 0, 0, 0, 0, 1, 0};
        tbl[1]  = '{1, 2, 0, 0, 0, 0, 2, 0};
        tbl[2]  = '{1, 3, 0, 0, 0, 0, 3, 0};
        tbl[3]  = '{1, 4, 0, 0, 0, 0, 4, 0};
        tbl[4]  = '{0, 0, 1, 0, 0, 1, 4, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 1, 4, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 4, 0};
        tbl[7]  = '{0, 0, 0, c[1], 1, 1, 3, 0};
        tbl[8]  = '{0, 0, 0, c[1], 0, 1, 3, 0};
        tbl[9]  = '{0, 0, 0, c[1], 0, 1, 3, 0};
        tbl[10] = '{0, 0, 0, c[2], 1, 1, 2, 0};
        tbl[11] = '{0, 0, 0, c[2], 0, 1, 2, 0};
        tbl[12] = '{0, 0, 0, c[2], 0, 1, 2, 0};
        tbl[13] = '{0, 0, 0, c[3], 1, 1, 1, 0};
        tbl[14] = '{0, 0, 0, c[3], 0, 1, 1, 0};
        tbl[15] = '{0, 0, 0, c[3], 0, 1, 1, 0};
        tbl[16] = '{0, 0, 0, c[4], 1, 1, 0, 0};
        tbl[17] = '{0, 0, 0, c[4], 0, 1, 0, 0};
        tbl[18] = '{0, 0, 0, c[4], 0, 1, 0, 0};
        tbl[19] = '{0, 0, 0, c[4], 0, 1, 0, 1};
        rate_div = W'(2);
        do_reset();
        chk("rst.code", int'(dac_code), 0);
        chk("rst.level", int'(level), 0);
        chk("rst.flags", int'({dac_valid, busy, full, underflow, overflow}), 0);
        for (int i = 0; i < 20; i++) begin
            wr = tbl[i].wr != 0;
            din = 16'(tbl[i].din);
            start = tbl[i].start != 0;
            cyc();
            chk($sformatf("vec%0d.code", i), int'(dac_code), tbl[i].code);
            chk($sformatf("vec%0d.valid", i), int'(dac_valid), tbl[i].valid);
            chk($sformatf("vec%0d.busy", i), int'(busy), tbl[i].busy);
            chk($sformatf("vec%0d.level", i), int'(level), tbl[i].lvl);
            chk($sformatf("vec%0d.uf", i), int'(underflow), tbl[i].uf);
        end
        // loop mode replay and restart from the loop base
        do_reset();
        rate_div = '0;
        for (int k = 0; k < 3; k++) begin
            wr = 1'b1; din = 16'('h0A + k); cyc();
        end
        clr();
        start = 1'b1; loop_en = 1'b1; seen.delete(); cyc();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            chk("loop.level", int'(level), 3);
        end
        chk("loop.count", seen.size(), 7);
        for (int k = 0; k < 7; k++)
            chk($sformatf("loop.code%0d", k), k < seen.size() ? int'(seen[k]) : -1, int'(cv(P'(lp[k]))));
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("loop.stop.busy", int'(busy), 0);
        seen.delete();
        start = 1'b1; loop_en = 1'b1; cyc(); start = 1'b0;
        cyc();
        cyc();
        chk("loop.replay0", seen.size() > 0 ? int'(seen[0]) : -1, int'(cv(P'('h0A))));
        chk("loop.replay1", seen.size() > 1 ? int'(seen[1]) : -1, int'(cv(P'('h0B))));
        wr = 1'b1; din = 16'h0077; cyc(); wr = 1'b0;
        chk("loop.wr.of", int'(overflow), 1);
        chk("loop.wr.level", int'(level), 3);
        // fill past capacity, then drain
        do_reset();
        rate_div = '0;
        for (int k = 0; k < DEPTH; k++) begin
            wr = 1'b1; din = 16'(k); cyc();
        end
        chk("fill.full", int'(full), 1);
        chk("fill.of0", int'(overflow), 0);
        din = 16'h0155; cyc(); wr = 1'b0;
        chk("fill.level", int'(level), DEPTH);
        chk("fill.of1", int'(overflow), 1);
        seen.delete();
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 0; k < DEPTH + 4; k++) cyc();
        chk("drain.count", seen.size(), DEPTH);
        ord = 0;
        foreach (seen[k]) if (seen[k] != cv(P'(k))) ord++;
        chk("drain.order", ord, 0);
        chk("drain.uf", int'(underflow), 1);
        // stream while the host refills one word per cycle
        do_reset();
        rate_div = '0;
        wr = 1'b1; din = 16'h0100; cyc();
        wr = 1'b0; start = 1'b1; seen.delete(); cyc(); start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            wr = 1'b1; din = 16'('h100 + k); cyc();
            chk("refill.level", int'(level), 1);
        end
        wr = 1'b0; cyc();
        chk("refill.uf", int'(underflow), 0);
        chk("refill.count", seen.size(), 17);
        ord = 0;
        foreach (seen[k]) if (seen[k] != cv(P'('h100 + k))) ord++;
        chk("refill.order", ord, 0);
        stop = 1'b1; cyc(); stop = 1'b0;
        // start on empty, then start and stop together
        do_reset();
        start = 1'b1; cyc(); start = 1'b0;
        chk("empty.busy", int'(busy), 0);
        chk("empty.uf", int'(underflow), 1);
        wr = 1'b1; din = 16'h0055; cyc(); wr = 1'b0;
        seen.delete();
        start = 1'b1; stop = 1'b1; cyc(); clr();
        cyc(); cyc();
        chk("ss.busy", int'(busy), 0);
        chk("ss.emitted", seen.size(), 0);
        chk("ss.level", int'(level), 1);
        // reset in the middle of playback
        do_reset();
        rate_div = W'(5);
        for (int k = 0; k < 3; k++) begin
            wr = 1'b1; din = 16'('h20 + k); cyc();
        end
        wr = 1'b0; start = 1'b1; seen.delete(); cyc(); start = 1'b0;
        for (int k = 0; k < 8; k++) cyc();
        chk("midrst.emitted", seen.size(), 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("midrst.code", int'(dac_code), 0);
        chk("midrst.level", int'(level), 0);
        chk("midrst.flags", int'({dac_valid, busy, full, underflow, overflow}), 0);
        // code conversion of a full-scale word
        do_reset();
        rate_div = '0;
        wr = 1'b1; din = 16'hF3FF; cyc(); wr = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        chk("tc.code", int'(dac_code), TC_EXP);
        // randomized traffic against the model
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            wr = ($urandom % 2) == 0;
            din = 16'($urandom);
            start = ($urandom % 20) == 0;
            stop = ($urandom % 40) == 0;
            loop_en = ($urandom % 2) == 0;
            rst = ($urandom % 500) == 0;
            if (m_st == 0 && ($urandom % 8) == 0) rate_div = W'($urandom % 4);
            cyc();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
